sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 148 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Refresh / write-burst / read-burst arbiter in front of an
//               SDRAM command engine, with refresh interval timer.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
  parameter int REF_PERIOD = 782,
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              wr_done,
  input  logic              rd_done,
  input  logic              ref_done,
  output logic              wr_en,
  output logic              rd_en,
  output logic              ref_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              ref_overrun
);

  localparam int                TMR_W       = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TMR_W-1:0]  C_TMR_LAST  = TMR_W'(REF_PERIOD - 1);
  localparam logic [TMR_W-1:0]  C_TMR_ONE   = TMR_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_STEP = ADDR_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_READ    = 2'd2,
    S_REFRESH = 2'd3
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_ref_pend;
  logic             r_last_wr;
  logic             r_armed;

  logic             w_tc;
  logic             w_ref_served;
  logic             w_pick_wr;
  logic             w_pick_rd;

  assign w_tc         = init_done && (r_tmr == C_TMR_LAST);
  assign w_ref_served = (r_state == S_REFRESH) && ref_done;
  // Write wins unless a read is also waiting and the last grant was a write.
  assign w_pick_wr    = wr_req && (!rd_req || !r_last_wr);
  assign w_pick_rd    = rd_req && !w_pick_wr;

  // Refresh interval timer, pending request and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr       <= '0;
      r_ref_pend  <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      if (!init_done || w_tc) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + C_TMR_ONE;
      end

      // A refresh finishing on the terminal-count edge is not a miss.
      if (w_tc) begin
        r_ref_pend <= 1'b1;
        if (r_ref_pend && !w_ref_served) begin
          ref_overrun <= 1'b1;
        end
      end else if (w_ref_served) begin
        r_ref_pend <= 1'b0;
      end
    end
  end

  // Arbitration FSM with registered grants and burst address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      ref_en    <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      r_last_wr <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (init_done && r_armed) begin
            if (r_ref_pend) begin
              r_state <= S_REFRESH;
              ref_en  <= 1'b1;
            end else if (w_pick_wr) begin
              r_state   <= S_WRITE;
              wr_en     <= 1'b1;
              r_last_wr <= 1'b1;
            end else if (w_pick_rd) begin
              r_state   <= S_READ;
              rd_en     <= 1'b1;
              r_last_wr <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (wr_done) begin
            r_state <= S_IDLE;
            wr_en   <= 1'b0;
            wr_addr <= wr_addr + C_ADDR_STEP;
          end
        end
        S_READ: begin
          if (rd_done) begin
            r_state <= S_IDLE;
            rd_en   <= 1'b0;
            rd_addr <= rd_addr + C_ADDR_STEP;
          end
        end
        S_REFRESH: begin
          if (ref_done) begin
            r_state <= S_IDLE;
            ref_en  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
          ref_en  <= 1'b0;
        end
      endcase
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({wr_en, rd_en, ref_en}));

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Scoreboard bench for sdram_arbiter against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int REF_PERIOD = 16;
  localparam int BURST_LEN  = 8;
  localparam int ADDR_W     = 8;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_REF  = 3;

  logic              clk, rst_n, init_done, wr_req, rd_req;
  logic              wr_done, rd_done, ref_done;
  logic              wr_en, rd_en, ref_en, ref_overrun;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  sdram_arbiter #(
    .REF_PERIOD (REF_PERIOD),
    .BURST_LEN  (BURST_LEN),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_done   (init_done),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_done     (wr_done),
    .rd_done     (rd_done),
    .ref_done    (ref_done),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .ref_en      (ref_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .ref_overrun (ref_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int kind;
    int addr;
    int cyc;
  } exp_t;

  exp_t sb_q[$];

  int m_busy, m_last_wr, m_since_init, m_owed, m_overrun;
  int m_waddr, m_raddr, m_alive;
  int cyc = 0;

  task automatic model_reset();
    m_busy = K_NONE; m_last_wr = 0; m_since_init = 0; m_owed = 0;
    m_overrun = 0; m_waddr = 0; m_raddr = 0; m_alive = 0;
    sb_q.delete();
  endtask

  task automatic model_start(input int k);
    exp_t e;
    m_busy = k;
    if (k == K_WR) m_last_wr = 1;
    if (k == K_RD) m_last_wr = 0;
    e.kind = k;
    e.addr = (k == K_WR) ? m_waddr : (k == K_RD) ? m_raddr : 0;
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  task automatic model_step();
    bit served_ref, boundary, allowed;
    cyc++;
    served_ref = (m_busy == K_REF) && ref_done;
    allowed    = (m_alive >= 1);
    m_alive++;
    boundary   = 1'b0;
    // A refresh is owed after every REF_PERIOD consecutive initialised edges.
    if (init_done) begin
      m_since_init++;
      boundary = ((m_since_init % REF_PERIOD) == 0);
    end else begin
      m_since_init = 0;
    end
    case (m_busy)
      K_NONE: if (init_done && allowed) begin
        if (m_owed != 0)                              model_start(K_REF);
        else if (wr_req && (!rd_req || m_last_wr == 0)) model_start(K_WR);
        else if (rd_req)                              model_start(K_RD);
      end
      K_WR: if (wr_done) begin
        m_busy  = K_NONE;
        m_waddr = (m_waddr + BURST_LEN) % (1 << ADDR_W);
      end
      K_RD: if (rd_done) begin
        m_busy  = K_NONE;
        m_raddr = (m_raddr + BURST_LEN) % (1 << ADDR_W);
      end
      default: if (ref_done) m_busy = K_NONE;
    endcase
    if (boundary) begin
      if (m_owed != 0 && !served_ref) m_overrun = 1;
      m_owed = 1;
    end else if (served_ref) begin
      m_owed = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int prev_vec = 0;
    int vec, exp_vec, kind, addr;
    exp_t e;
    forever begin
      @(negedge clk);
      vec     = {29'd0, wr_en, rd_en, ref_en};
      exp_vec = (m_busy == K_WR) ? 4 : (m_busy == K_RD) ? 2 : (m_busy == K_REF) ? 1 : 0;
      check("grant_vec", vec, exp_vec);
      check("wr_addr", int'(wr_addr), m_waddr);
      check("rd_addr", int'(rd_addr), m_raddr);
      check("ref_overrun", int'(ref_overrun), m_overrun);
      if (vec != 0 && vec != prev_vec) begin
        kind = (vec == 4) ? K_WR : (vec == 2) ? K_RD : (vec == 1) ? K_REF : -1;
        addr = (kind == K_WR) ? int'(wr_addr) : (kind == K_RD) ? int'(rd_addr) : 0;
        if (sb_q.size() == 0) begin
          check("unexpected_grant", kind, K_NONE);
        end else begin
          e = sb_q.pop_front();
          check("grant_kind", kind, e.kind);
          check("grant_addr", addr, e.addr);
          check("grant_cycle", cyc, e.cyc);
        end
      end
      prev_vec = vec;
    end
  end

  // ---------------- command engine responder ----------------
  int eng_min = 0, eng_max = 0;
  bit eng_stray = 0;

  initial begin
    int cnt = 0, tgt = 0;
    bit was_busy = 0;
    wr_done = 1'b0; rd_done = 1'b0; ref_done = 1'b0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0; rd_done = 1'b0; ref_done = 1'b0;
      if (wr_en || rd_en || ref_en) begin
        if (!was_busy) begin
          tgt = int'($urandom_range(eng_max, eng_min));
          cnt = 0;
        end
        was_busy = 1;
        if (cnt >= tgt) begin
          if (wr_en)      wr_done  = 1'b1;
          else if (rd_en) rd_done  = 1'b1;
          else            ref_done = 1'b1;
          was_busy = 0;
          cnt      = 0;
        end else begin
          cnt++;
        end
      end else begin
        was_busy = 0;
      end
      // Non-matching completion pulses the arbiter must ignore.
      if (eng_stray && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       if (!wr_en)  wr_done  = 1'b1;
          1:       if (!rd_en)  rd_done  = 1'b1;
          default: if (!ref_en) ref_done = 1'b1;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {12'd0, wr_en, rd_en, ref_en, ref_overrun, wr_addr, rd_addr}, 0);
    rst_n = 1'b1;
  endtask

  task automatic set_eng(input int lo, input int hi, input bit stray);
    eng_min = lo; eng_max = hi; eng_stray = stray;
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    set_eng(0, 0, 0);
    do_reset();

    // Not initialised: requests and stray dones must produce nothing.
    init_done = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    set_eng(0, 0, 1);
    repeat (40) @(negedge clk);

    // Write-only bursts held for ten cycles each.
    set_eng(10, 10, 0);
    init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b0;
    repeat (60) @(negedge clk);

    // Both requesting with immediate completion: alternation, write first.
    init_done = 1'b0;
    do_reset();
    init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    set_eng(0, 0, 0);
    repeat (40) @(negedge clk);

    // Long write with no completion: refresh pends, then overruns.
    init_done = 1'b1; wr_req = 1'b1; rd_req = 1'b0;
    set_eng(40, 40, 0);
    do_reset();
    repeat (36) @(negedge clk);
    check("overrun_after_long_burst", int'(ref_overrun), 1);
    repeat (20) @(negedge clk);
    set_eng(0, 0, 0);

    // Many write bursts to wrap the write address.
    do_reset();
    repeat (300) @(negedge clk);

    // Randomised traffic with stray dones and occasional loss of init.
    do_reset();
    set_eng(0, 6, 1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      wr_req    = 1'($urandom_range(0, 1));
      rd_req    = 1'($urandom_range(0, 1));
      init_done = !((i % 300) >= 290);
    end

    // Asynchronous reset in the middle of a read burst.
    init_done = 1'b1; wr_req = 1'b0; rd_req = 1'b1;
    set_eng(20, 20, 0);
    for (int i = 0; i < 100 && !rd_en; i++) @(negedge clk);
    check("rd_grant_seen", int'(rd_en), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {12'd0, wr_en, rd_en, ref_en, ref_overrun, wr_addr, rd_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    #1;
    check("scoreboard_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
